sync_2ff: RTL and testbench

//  Multi-bit level synchronizer: carries a WIDTH-bit asynchronous input into the clk

---
 rtl/sync_2ff.sv | 36 +++
 tb/tb_sync_2ff.sv | 131 +++++++++++++
 2 files changed

// File: rtl/sync_2ff.sv
// Multi-bit level synchronizer: each bit of async_in passes independently through a
// chain of STAGES flops in the clk domain. Coherent only for single-bit (Gray) changes.
module sync_2ff #(
  parameter int              WIDTH     = 1,
  parameter int              STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  // Fewer than two flops gives no metastability protection, so clamp the depth.
  localparam int NUM_STAGES = (STAGES < 2) ? 2 : STAGES;

  (* ASYNC_REG = "TRUE", dont_touch = "true" *)
  logic [WIDTH-1:0] stage_r [NUM_STAGES];

  // Synchronizer chain: stage 0 captures the foreign-domain level, later stages only shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        stage_r[i] <= RESET_VAL;
      end
    end else begin
      stage_r[0] <= async_in;
      for (int i = 1; i < NUM_STAGES; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign sync_out = stage_r[NUM_STAGES-1];

endmodule

// File: tb/tb_sync_2ff.sv
// Randomized scoreboard bench for sync_2ff at depths 2 and 3; the reference model keeps
// the history of values sampled since the last reset and picks the one STAGES-1 edges old.
module tb_sync_2ff;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] async_in = 4'b0000;
  logic [3:0] out2;
  logic [3:0] out3;

  int errors = 0;
  int checks = 0;

  logic [3:0] hist[$];
  logic [3:0] exp2_q[$];
  logic [3:0] exp3_q[$];
  int         rst_count = 0;
  int         rst_seen  = 0;

  sync_2ff #(.WIDTH(4), .STAGES(2), .RESET_VAL(4'b0000)) dut2 (
    .clk(clk), .rst(rst), .async_in(async_in), .sync_out(out2));

  sync_2ff #(.WIDTH(4), .STAGES(3), .RESET_VAL(4'b0000)) dut3 (
    .clk(clk), .rst(rst), .async_in(async_in), .sync_out(out3));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Output after an edge = the sample taken s-1 edges earlier, or the reset value if
  // fewer than s samples have been taken since reset was last released.
  function automatic logic [3:0] model_out(int s);
    if (hist.size() >= s) return hist[hist.size() - s];
    return 4'b0000;
  endfunction

  always @(posedge rst) rst_count++;

  always @(posedge clk) begin
    if (rst) begin
      hist.delete();
      rst_seen = rst_count;
      exp2_q.push_back(4'b0000);
      exp3_q.push_back(4'b0000);
    end else begin
      if (rst_seen != rst_count) begin
        hist.delete();
        rst_seen = rst_count;
      end
      hist.push_back(async_in);
      exp2_q.push_back(model_out(2));
      exp3_q.push_back(model_out(3));
    end
  end

  // Monitor: compares both outputs shortly after every rising edge.
  initial begin
    logic [3:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (exp2_q.size() == 0 || exp3_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: got no expected entry, required one at t=%0t", $time);
      end else begin
        e = exp2_q.pop_front();
        check("sync_out_s2", out2, e);
        e = exp3_q.pop_front();
        check("sync_out_s3", out3, e);
      end
    end
  end

  initial begin
    logic [3:0] v;
    #1;
    check("reset_hold_s2", out2, 4'b0000);
    check("reset_hold_s3", out3, 4'b0000);
    #1 rst = 1'b0;
    #10 async_in = 4'b1010;
    #20 async_in = 4'b1100;
    #20 async_in = 4'b1111;
    #16 rst = 1'b1;
    #1;
    check("async_reset_s2", out2, 4'b0000);
    check("async_reset_s3", out3, 4'b0000);
    #2 rst = 1'b0;

    repeat (400) begin
      @(posedge clk);
      #3;
      case ($urandom_range(0, 11))
        0, 1: begin
          v = async_in;
          async_in = ~v;
          #3 async_in = v;
        end
        2: begin
          #1 rst = 1'b1;
          #1;
          check("async_reset_s2", out2, 4'b0000);
          check("async_reset_s3", out3, 4'b0000);
          #1 rst = 1'b0;
        end
        3: begin
          rst = 1'b1;
          #1;
          check("async_reset_s2", out2, 4'b0000);
          check("async_reset_s3", out3, 4'b0000);
          @(posedge clk);
          #3 rst = 1'b0;
        end
        4, 5, 6, 7: async_in = async_in ^ (4'b0001 << $urandom_range(0, 3));
        default: async_in = 4'($urandom_range(0, 15));
      endcase
    end

    repeat (5) @(posedge clk);
    #4;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
